ddr_seq_startup_ctrl: RTL

//  Multi-channel startup/recalibration gate between memory controllers, the PLL

---
 rtl/ddr_seq_startup_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ddr_seq_startup_ctrl.sv
// Startup/recalibration gate between memory controllers, PLL reconfig and NUM_CH PHY sequencers.
// Releases all channels together after busy flags settle and supervises calibration with a timeout.
module ddr_seq_startup_ctrl #(
    parameter int NUM_CH         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_WIDTH  = 24,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit BYPASS         = 1'b0
) (
    input  logic              seq_clk,
    input  logic              reset_seq,
    input  logic [NUM_CH-1:0] ctl_init_done,
    input  logic [NUM_CH-1:0] phs_shft_busy,
    input  logic              recal_req,
    input  logic [NUM_CH-1:0] ctl_usr_mode_rdy,
    input  logic [NUM_CH-1:0] training_data_write_successful,
    input  logic [NUM_CH-1:0] postamble_successful,
    input  logic [NUM_CH-1:0] resynchronisation_successful,
    output logic [NUM_CH-1:0] ctl_init_done_for_seq,
    output logic [NUM_CH-1:0] phs_shft_busy_for_seq,
    output logic              seq_restart,
    output logic [NUM_CH-1:0] tracking_successful,
    output logic              all_cal_done,
    output logic              cal_timeout,
    output logic [2:0]        startup_state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_PHS = 3'd1;
    localparam logic [2:0] SETTLE   = 3'd2;
    localparam logic [2:0] GO       = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;
    localparam logic [2:0] RESTART  = 3'd5;
    localparam logic [2:0] FAIL     = 3'd6;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]            SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [NUM_CH-1:0]        sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]        busy_s;
    logic [2:0]               state, state_nxt;
    logic [SW-1:0]            settle_cnt, settle_nxt;
    logic [TIMEOUT_WIDTH-1:0] to_cnt, to_nxt;
    logic                     enable;
    logic                     timeout_hit;
    logic                     all_init, any_busy, all_rdy;

    assign busy_s   = sync_q[SYNC_STAGES-1];
    assign all_init = &ctl_init_done;
    assign any_busy = |busy_s;
    assign all_rdy  = &ctl_usr_mode_rdy;

    // Chain resets to all ones so an unknown PLL is treated as busy.
    always_ff @(posedge seq_clk or posedge reset_seq) begin
        if (reset_seq) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= phs_shft_busy;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        state_nxt   = state;
        settle_nxt  = '0;
        to_nxt      = '0;
        timeout_hit = 1'b0;
        if (BYPASS) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (all_init) state_nxt = any_busy ? WAIT_PHS : SETTLE;
                RESTART: state_nxt = IDLE;
                WAIT_PHS, SETTLE, GO, DONE, FAIL: begin
                    if (!all_init) begin
                        state_nxt = IDLE;
                    end else if (recal_req && (state == GO || state == DONE || state == FAIL)) begin
                        state_nxt = RESTART;
                    end else begin
                        case (state)
                            WAIT_PHS: if (!any_busy) state_nxt = SETTLE;
                            SETTLE: begin
                                if (any_busy)                       state_nxt = WAIT_PHS;
                                else if (settle_cnt == SETTLE_LAST) state_nxt = GO;
                                else                                settle_nxt = settle_cnt + 1'b1;
                            end
                            GO: begin
                                // Calibration completing on the last allowed cycle still counts as success.
                                if (all_rdy) begin
                                    state_nxt = DONE;
                                end else if (to_cnt == TIMEOUT_LAST) begin
                                    state_nxt   = FAIL;
                                    timeout_hit = 1'b1;
                                end else begin
                                    to_nxt = to_cnt + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge seq_clk or posedge reset_seq) begin
        if (reset_seq) begin
            state               <= IDLE;
            settle_cnt          <= '0;
            to_cnt              <= '0;
            enable              <= 1'b0;
            seq_restart         <= 1'b0;
            all_cal_done        <= 1'b0;
            cal_timeout         <= 1'b0;
            tracking_successful <= '0;
        end else begin
            state        <= state_nxt;
            settle_cnt   <= settle_nxt;
            to_cnt       <= to_nxt;
            enable       <= (state_nxt == GO) || (state_nxt == DONE);
            seq_restart  <= (state_nxt == RESTART);
            all_cal_done <= BYPASS ? all_rdy : (state_nxt == DONE);
            if (timeout_hit) cal_timeout <= 1'b1;
            tracking_successful <= training_data_write_successful & postamble_successful
                                 & resynchronisation_successful & ctl_usr_mode_rdy;
        end
    end

    assign ctl_init_done_for_seq = BYPASS ? ctl_init_done : (ctl_init_done & {NUM_CH{enable}});
    assign phs_shft_busy_for_seq = BYPASS ? phs_shft_busy : (busy_s & {NUM_CH{enable}});
    assign startup_state         = state;

endmodule
